// File: rtl/zap_dbus_access.sv
// zap_dbus_access: data-bus access stage. It turns one load/store request into a single-outstanding
//   strobe/ack bus cycle with word-aligned address, byte selects and replicated store data.
// Latency: request cycle 0, strobe from cycle 1, ack in cycle k -> o_mem_valid in cycle k+1 (min 3 cycles/access).
// Backpressure: o_data_stall freezes upstream while a request is accepted or the bus cycle is in flight.
// Ports: i_clk/i_reset_n (async active-low); i_mem_* request side; o_dbus_*/i_dbus_* bus side;
//   o_mem_* completion side (raw read word, addr[1:0], fault 00 none / 01 align / 10 bus err or timeout).
module zap_dbus_access #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_clear_from_writeback,
    input  logic        i_mem_req,
    input  logic        i_mem_load,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wr_data,
    input  logic        i_sbyte,
    input  logic        i_ubyte,
    input  logic        i_shalf,
    input  logic        i_uhalf,
    output logic        o_dbus_stb,
    output logic        o_dbus_we,
    output logic [31:0] o_dbus_addr,
    output logic [3:0]  o_dbus_sel,
    output logic [31:0] o_dbus_wdata,
    input  logic        i_dbus_ack,
    input  logic        i_dbus_err,
    input  logic [31:0] i_dbus_rdata,
    output logic        o_data_stall,
    output logic        o_mem_valid,
    output logic [31:0] o_mem_rd_data,
    output logic [1:0]  o_mem_address_ff,
    output logic [1:0]  o_mem_fault
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [1:0] FAULT_NONE  = 2'b00;
    localparam logic [1:0] FAULT_ALIGN = 2'b01;
    localparam logic [1:0] FAULT_BUS   = 2'b10;

    state_t      state, state_nxt;
    logic        stb_q, stb_nxt;
    logic        we_q, we_nxt;
    logic [31:0] addr_q, addr_nxt;
    logic [3:0]  sel_q, sel_nxt;
    logic [31:0] wdata_q, wdata_nxt;
    logic [31:0] wdog_q, wdog_nxt;
    logic        flush_q, flush_nxt;
    logic [1:0]  req_lo_q, req_lo_nxt;
    logic [31:0] rd_q, rd_nxt;
    logic [1:0]  addr_ff_q, addr_ff_nxt;
    logic [1:0]  fault_q, fault_nxt;

    logic        is_byte, is_half;
    logic [3:0]  sel_c;
    logic [31:0] wdata_c;
    logic [31:0] wdog_inc;
    logic        timeout;
    logic        flush_any;

    assign is_byte  = i_sbyte | i_ubyte;
    assign is_half  = i_shalf | i_uhalf;
    assign wdog_inc = wdog_q + 32'd1;
    // Count reaches the limit on the BUS_TIMEOUT-th BUSY cycle, so the strobe is high exactly that long.
    assign timeout  = (BUS_TIMEOUT != 0) && (wdog_inc == 32'(BUS_TIMEOUT));
    // A flush arriving on the terminating cycle itself still cancels the completion.
    assign flush_any = flush_q | i_clear_from_writeback;

    // Byte lanes and replicated store data; loads use the same selects.
    always_comb begin
        sel_c   = 4'b1111;
        wdata_c = i_mem_wr_data;
        if (is_byte) begin
            sel_c   = 4'b0001 << i_mem_addr[1:0];
            wdata_c = {4{i_mem_wr_data[7:0]}};
        end else if (is_half) begin
            sel_c   = i_mem_addr[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{i_mem_wr_data[15:0]}};
        end
    end

    always_comb begin
        state_nxt   = state;
        stb_nxt     = stb_q;
        we_nxt      = we_q;
        addr_nxt    = addr_q;
        sel_nxt     = sel_q;
        wdata_nxt   = wdata_q;
        wdog_nxt    = wdog_q;
        flush_nxt   = flush_q;
        req_lo_nxt  = req_lo_q;
        rd_nxt      = rd_q;
        addr_ff_nxt = addr_ff_q;
        fault_nxt   = fault_q;
        case (state)
            IDLE: begin
                if (i_mem_req && !i_clear_from_writeback) begin
                    if (is_half && i_mem_addr[0]) begin
                        // Odd halfword: report without touching the bus.
                        state_nxt   = DONE;
                        fault_nxt   = FAULT_ALIGN;
                        addr_ff_nxt = i_mem_addr[1:0];
                    end else begin
                        state_nxt  = BUSY;
                        stb_nxt    = 1'b1;
                        we_nxt     = !i_mem_load;
                        addr_nxt   = {i_mem_addr[31:2], 2'b00};
                        sel_nxt    = sel_c;
                        wdata_nxt  = wdata_c;
                        wdog_nxt   = 32'd0;
                        flush_nxt  = 1'b0;
                        req_lo_nxt = i_mem_addr[1:0];
                    end
                end
            end
            BUSY: begin
                wdog_nxt  = wdog_inc;
                flush_nxt = flush_any;
                if (i_dbus_err || i_dbus_ack || timeout) begin
                    stb_nxt   = 1'b0;
                    flush_nxt = 1'b0;
                    if (flush_any) begin
                        state_nxt = IDLE;
                        fault_nxt = FAULT_NONE;
                    end else begin
                        state_nxt   = DONE;
                        addr_ff_nxt = req_lo_q;
                        if (i_dbus_err) begin
                            fault_nxt = FAULT_BUS;
                        end else if (i_dbus_ack) begin
                            fault_nxt = FAULT_NONE;
                            if (!we_q) rd_nxt = i_dbus_rdata;
                        end else begin
                            fault_nxt = FAULT_BUS;
                        end
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                if (i_clear_from_writeback) fault_nxt = FAULT_NONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= IDLE;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            sel_q     <= 4'd0;
            wdata_q   <= 32'd0;
            wdog_q    <= 32'd0;
            flush_q   <= 1'b0;
            req_lo_q  <= 2'd0;
            rd_q      <= 32'd0;
            addr_ff_q <= 2'd0;
            fault_q   <= 2'd0;
        end else begin
            state     <= state_nxt;
            stb_q     <= stb_nxt;
            we_q      <= we_nxt;
            addr_q    <= addr_nxt;
            sel_q     <= sel_nxt;
            wdata_q   <= wdata_nxt;
            wdog_q    <= wdog_nxt;
            flush_q   <= flush_nxt;
            req_lo_q  <= req_lo_nxt;
            rd_q      <= rd_nxt;
            addr_ff_q <= addr_ff_nxt;
            fault_q   <= fault_nxt;
        end
    end

    assign o_dbus_stb       = stb_q;
    assign o_dbus_we        = we_q;
    assign o_dbus_addr      = addr_q;
    assign o_dbus_sel       = sel_q;
    assign o_dbus_wdata     = wdata_q;
    assign o_mem_rd_data    = rd_q;
    assign o_mem_address_ff = addr_ff_q;
    assign o_data_stall     = ((state == IDLE) && i_mem_req && !i_clear_from_writeback) || (state == BUSY);
    // A flush during DONE hides the completion in that same cycle.
    assign o_mem_valid      = (state == DONE) && !i_clear_from_writeback;
    assign o_mem_fault      = ((state == DONE) && i_clear_from_writeback) ? FAULT_NONE : fault_q;

endmodule

// File: doc/zap_dbus_access.md
# zap_dbus_access

Data-bus access stage between the ALU/memory-request stage and `zap_memory_main`. It takes one load/store request per instruction and generates the word-aligned bus address, byte selects and replicated store data. It runs a single-outstanding strobe/acknowledge bus cycle with a watchdog, and stalls the pipeline until the access completes. It returns raw 32-bit read data, the low address bits and a fault code, which the downstream stage uses for rotation and sign extension.

## Interface
- `BUS_TIMEOUT`, default 255: BUSY cycles without ack/err before a timeout fault is forced; 0 disables the watchdog.
- `i_clk`  in  1  clock.
- `i_reset_n`  in  1  reset; asynchronous, active-low.
- `i_clear_from_writeback`  in  1  pipeline flush.
- `i_mem_req`  in  1  request valid; held stable by upstream while `o_data_stall`=1.
- `i_mem_load`  in  1  1 = load, 0 = store.
- `i_mem_addr`  in  32  byte address.
- `i_mem_wr_data`  in  32  store data, right-justified.
- `i_sbyte`, `i_ubyte`, `i_shalf`, `i_uhalf`  in  1 each  access size; all 0 = word.
- `o_dbus_stb`  out  1  bus strobe.
- `o_dbus_we`  out  1  write enable.
- `o_dbus_addr`  out  32  `{addr[31:2],2'b00}`.
- `o_dbus_sel`  out  4  byte selects.
- `o_dbus_wdata`  out  32  replicated store data.
- `i_dbus_ack`  in  1  cycle complete.
- `i_dbus_err`  in  1  bus error.
- `i_dbus_rdata`  in  32  read data, valid with ack.
- `o_data_stall`  out  1  freeze upstream stages.
- `o_mem_valid`  out  1  one-cycle completion pulse.
- `o_mem_rd_data`  out  32  captured raw read word.
- `o_mem_address_ff`  out  2  `addr[1:0]` of the completed access.
- `o_mem_fault`  out  2  00 none, 01 alignment, 10 bus error/timeout.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE, with `i_mem_req`=1 and no clear:
  - Halfword (`i_shalf|i_uhalf`) with `addr[0]`=1: no bus cycle; go to DONE with fault 01.
  - Otherwise: register the bus outputs, set `o_dbus_stb`=1, clear the watchdog, go to BUSY.
- Byte selects and store data:
  - Byte: sel = `4'b0001<<addr[1:0]`, wdata = `{4{d[7:0]}}`.
  - Half: sel = `addr[1]` ? 1100 : 0011, wdata = `{2{d[15:0]}}`.
  - Word: sel = 1111, wdata = d. Misaligned word addresses are allowed; the address is forced aligned.
  - Loads drive the same sel; wdata is don't-care, `o_dbus_we`=0.
- BUSY:
  - Bus outputs are held constant and the watchdog increments each cycle.
  - On `i_dbus_ack`: capture rdata (loads only), fault 00.
  - On `i_dbus_err`, or watchdog == `BUS_TIMEOUT` (when nonzero): fault 10.
  - Priority: err > ack > timeout.
  - On any of these terminations, drop `o_dbus_stb` and go to DONE.
- DONE: `o_mem_valid`=1 and fault/data are presented for this one cycle; go to IDLE. Upstream advances on this edge.
- `o_mem_rd_data`, `o_mem_address_ff` and `o_mem_fault` hold until the next completion.
- Flush:
  - In IDLE: the request is ignored.
  - In BUSY: a flush flag is set and the bus cycle runs to ack/err/timeout, then goes to IDLE with no `o_mem_valid` and no fault.
  - In DONE: `o_mem_valid` is suppressed and the fault is cleared to 00.

## Timing
- Reset values:
  - All registered outputs 0; watchdog 0; flush flag 0; state IDLE.
  - `o_data_stall` = `i_mem_req & !i_clear_from_writeback` while in IDLE, even during reset.
- `o_data_stall` is combinational: (IDLE & `i_mem_req` & !clear) | BUSY. It is 0 in DONE.
- Latency: request seen in cycle 0; stb high from cycle 1; ack in cycle k (k ≥ 1) gives DONE in cycle k+1, then IDLE in cycle k+2.
- Minimum 3 cycles per access; back-to-back requests are accepted in the IDLE cycle after DONE.
- Alignment fault: DONE in cycle 1, no stb ever asserted.
- Timeout: ack-less BUSY for `BUS_TIMEOUT` cycles terminates on the cycle the count is reached.
- Ack in the same cycle as the timeout count: ack wins, fault 00.
- Asynchronous reset mid-BUSY drops stb immediately; no completion is reported.
- Bus contract: at most one outstanding cycle; ack/err are sampled only while stb=1.

## Test plan
- Word load, addr 0x1003, ack after 2 cycles with rdata 0xAABBCCDD:
  - Bus: addr 0x1000, sel 1111, we 0.
  - Completion: `o_mem_valid` pulse, rd_data 0xAABBCCDD, address_ff 3, fault 00.
  - Stall high for exactly 3 cycles.
- Byte store, data 0x12345678, addr 0x22:
  - Bus: sel 0100, wdata 0x78787878, we 1. No rd_data update.
- Uhalf load at addr 0x5:
  - No stb; fault 01 in the DONE cycle; stall high for 1 cycle.
- `i_dbus_err` and `i_dbus_ack` together in cycle 2:
  - Fault 10; rd_data unchanged.
- `BUS_TIMEOUT`=4, never ack:
  - stb high for 4 cycles, then DONE with fault 10.
  - Next request accepted 2 cycles later.
- Flush in the first BUSY cycle, ack 3 cycles later:
  - stb held until the ack; then IDLE with no `o_mem_valid` and fault 00.
- Assert `i_reset_n`=0 mid-BUSY:
  - stb, valid and fault go to 0 immediately; state IDLE.
